mmio_uart_tx: RTL



---
 rtl/mmio_uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/mmio_uart_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state encoding.
package mmio_uart_pkg;

  // Word offsets within the 16-byte window (address[3:2])
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  // STATUS register bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO. A push while full is dropped, even when a
// pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for pointers and count; pointers wrap naturally (DEPTH is 2^AW)
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, STATUS/overflow logic,
// TX FIFO and the serialising FSM. hit/rdata are combinational so the core
// can take them in its same-cycle read.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [1:0]    off;
  logic          wr_tx, wr_st;
  logic          fifo_full, fifo_empty, pop;
  logic [AW:0]   fifo_count;
  logic [7:0]    fifo_head;
  logic          ovf_q, ovf_d;
  logic [31:0]   status;
  tx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          baud_done;
  logic          unused_bits;

  // Byte lane select and upper write-data bits carry no meaning here
  assign unused_bits = ^{address[1:0], wdata[31:8]};

  assign off   = address[3:2];
  assign hit   = (address[31:4] == BASE_ADDR[31:4]);
  assign wr_tx = hit & we & (off == OFF_TXDATA);
  assign wr_st = hit & we & (off == OFF_STATUS);

  // The FSM takes a byte either when idle or at the last stop-bit cycle,
  // which gives back-to-back frames without an idle gap.
  assign baud_done = (baud_q == BAUD_LAST);
  assign pop = ~fifo_empty &
               ((state_q == IDLE) | ((state_q == STOP) & baud_done));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_tx),
    .pop_i   (pop),
    .wdata_i (wdata[7:0]),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Sticky overflow: a dropped push sets it and wins over a same-cycle clear
  assign ovf_d = (wr_tx & fifo_full) | (ovf_q & ~(wr_st & wdata[ST_OVF]));

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  // STATUS word assembly and side-effect-free read mux
  always_comb begin
    status                            = '0;
    status[ST_FULL]                   = fifo_full;
    status[ST_EMPTY]                  = fifo_empty;
    status[ST_BUSY]                   = (state_q != IDLE);
    status[ST_OVF]                    = ovf_q;
    status[ST_CNT_LSB +: AW+1]        = fifo_count;
    rdata = (hit && off == OFF_STATUS) ? status : '0;
  end

  // Transmit FSM: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_head;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= fifo_head;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx = tx_q;

endmodule
